sobel_grad_sq_stream: RTL and testbench

- Streaming Sobel front end that sits directly upstream of the approximate square-root stage (squareroot_AHSQR_k8, 16-bit R in, 8-bit Q out).
- Accepts 8-bit grayscale pixels in raster order and buffers two image lines to form a 3x3 window.
- Computes Gx and Gy and emits R = Gx^2 + Gy^2, saturated to 16 bits, ready to drive the sqrt input directly.
- Feed-forward pipeline with valid tagging; no backpressure.

---
 rtl/sobel_grad_sq_stream_if.sv | 22 ++
 rtl/sobel_grad_sq_stream.sv | 147 ++++++++++++++
 tb/tb_sobel_grad_sq_stream.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_grad_sq_stream_if.sv
// Pixel-in / squared-gradient-out stream bundle for the Sobel front end.
// The master side drives pixels; the slave side is the Sobel block itself.
interface sobel_grad_sq_stream_if #(
    parameter int PIX_W = 8,
    parameter int R_W   = 16
);
    logic             sof;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_in;
    logic             r_valid;
    logic [R_W-1:0]   r_out;

    modport master (
        output sof, pix_valid, pix_in,
        input  r_valid, r_out
    );

    modport slave (
        input  sof, pix_valid, pix_in,
        output r_valid, r_out
    );
endinterface

// File: rtl/sobel_grad_sq_stream.sv
// Streaming 3x3 Sobel front end: two line buffers feed a shift window, then
// Gx/Gy -> squares -> saturated Gx^2+Gy^2, sized to drive the sqrt stage directly.
module sobel_grad_sq_stream #(
    parameter int IMG_W = 16,
    parameter int PIX_W = 8,
    parameter int R_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sobel_grad_sq_stream_if.slave bus
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int G_W   = PIX_W + 3;
    localparam int A_W   = PIX_W + 2;
    localparam int SQ_W  = 2 * A_W;
    localparam int SUM_W = SQ_W + 1;
    localparam int CMP_W = (SUM_W > R_W) ? SUM_W : R_W;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    logic                    accept;
    logic [COL_W-1:0]        col, col_eff, col_next;
    logic [1:0]              row, row_eff, row_next;
    logic                    launch;

    logic [PIX_W-1:0]        lb_r1 [IMG_W];
    logic [PIX_W-1:0]        lb_r2 [IMG_W];
    logic [PIX_W-1:0]        up1, up2;
    logic [PIX_W-1:0]        win [3][3];
    logic                    win_v;

    logic signed [G_W-1:0]   gx, gy, s1_gx, s1_gy, gx_neg, gy_neg;
    logic [A_W-1:0]          gx_abs, gy_abs;
    logic                    s1_v;
    logic [SQ_W-1:0]         s2_gx2, s2_gy2;
    logic                    s2_v;
    logic [SUM_W-1:0]        sum;
    logic [R_W-1:0]          r_sat, r_out_q;
    logic                    r_valid_q;

    function automatic logic signed [G_W-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    assign accept = bus.pix_valid;

    // sof re-anchors the incoming pixel at (0,0); row only needs to count up to 2
    always_comb begin
        col_eff = bus.sof ? '0 : col;
        row_eff = bus.sof ? 2'd0 : row;
        if (col_eff == LAST_COL) begin
            col_next = '0;
            row_next = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
        end else begin
            col_next = col_eff + COL_W'(1);
            row_next = row_eff;
        end
        launch = accept && (row_eff == 2'd2) && (col_eff >= COL_W'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= 2'd0;
        end else if (accept) begin
            col <= col_next;
            row <= row_next;
        end
    end

    assign up1 = lb_r1[col_eff];
    assign up2 = lb_r2[col_eff];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_r1[col_eff] <= bus.pix_in;
            lb_r2[col_eff] <= up1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
            win_v <= 1'b0;
        end else begin
            win_v <= launch;
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= up2;
                win[1][2] <= up1;
                win[2][2] <= bus.pix_in;
            end
        end
    end

    // Row index 0 is the oldest line, column index 0 the oldest column
    always_comb begin
        gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    end

    always_comb begin
        gx_neg = -s1_gx;
        gy_neg = -s1_gy;
        gx_abs = s1_gx[G_W-1] ? gx_neg[A_W-1:0] : s1_gx[A_W-1:0];
        gy_abs = s1_gy[G_W-1] ? gy_neg[A_W-1:0] : s1_gy[A_W-1:0];
        sum    = {1'b0, s2_gx2} + {1'b0, s2_gy2};
        r_sat  = (CMP_W'(sum) > CMP_W'({R_W{1'b1}})) ? '1 : R_W'(sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_gx     <= '0;
            s1_gy     <= '0;
            s2_v      <= 1'b0;
            s2_gx2    <= '0;
            s2_gy2    <= '0;
            r_valid_q <= 1'b0;
            r_out_q   <= '0;
        end else begin
            s1_v      <= win_v;
            s2_v      <= s1_v;
            r_valid_q <= s2_v;
            if (win_v) begin
                s1_gx <= gx;
                s1_gy <= gy;
            end
            if (s1_v) begin
                s2_gx2 <= gx_abs * gx_abs;
                s2_gy2 <= gy_abs * gy_abs;
            end
            if (s2_v)
                r_out_q <= r_sat;
        end
    end

    assign bus.r_valid = r_valid_q;
    assign bus.r_out   = r_out_q;

endmodule

// File: tb/tb_sobel_grad_sq_stream.sv
// Self-checking bench: table-driven image patterns, hand-written sof/reset sequences
// and random streams, all scored against a full-frame Sobel reference model.
module tb_sobel_grad_sq_stream;
    localparam int IMG_W = 16;
    localparam int PIX_W = 8;
    localparam int R_W   = 16;
    localparam int ROWS  = 8;
    localparam int FRAME = ROWS * IMG_W;

    typedef enum int {PAT_CONST, PAT_HRAMP, PAT_DIAG, PAT_STEP10, PAT_STEP255, PAT_RAND} pat_t;

    typedef struct {
        string name;
        pat_t  pat;
        int    idle_pct;
        int    exp_count;
        int    exp_step;
        int    exp_flat;
    } vec_t;

    typedef struct {
        int value;
        int edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   edge_no = 0;
    int   acc22_edge = 0;
    int   m_row = 0;
    int   m_col = 0;
    exp_t exp_q[$];
    int   obs_q[$];
    int   obs_edge_q[$];
    logic [PIX_W-1:0] img [0:255][0:IMG_W-1];

    always #5 clk = ~clk;

    sobel_grad_sq_stream_if #(.PIX_W(PIX_W), .R_W(R_W)) bus ();

    sobel_grad_sq_stream #(.IMG_W(IMG_W), .PIX_W(PIX_W), .R_W(R_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Sobel magnitude-squared at window centre (r,c), straight from the stored frame
    function automatic int ref_r(input int r, input int c);
        int p [3][3];
        int gx, gy, s;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = int'(img[(r - 1 + i) % 256][c - 1 + j]);
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        s  = gx * gx + gy * gy;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic int isqrt(input int v);
        int q = 0;
        while ((q + 1) * (q + 1) <= v) q++;
        return q;
    endfunction

    function automatic void model_accept(input logic sof, input logic [PIX_W-1:0] p, input int acc_edge);
        exp_t e;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row % 256][m_col] = p;
        if (m_row >= 2 && m_col >= 2) begin
            e.value   = ref_r(m_row - 1, m_col - 1);
            e.edge_no = acc_edge + 3;
            exp_q.push_back(e);
        end
        m_col++;
        if (m_col == IMG_W) begin
            m_col = 0;
            m_row++;
        end
    endfunction

    function automatic logic [PIX_W-1:0] pix_of(input pat_t pat, input int r, input int c);
        int v;
        case (pat)
            PAT_CONST:   v = 100;
            PAT_HRAMP:   v = 2 * c;
            PAT_DIAG:    v = c + r;
            PAT_STEP10:  v = (c >= 8) ? 10 : 0;
            PAT_STEP255: v = (c >= 8) ? 255 : 0;
            default:     v = int'($urandom_range(255));
        endcase
        return PIX_W'(v);
    endfunction

    // Idle cycles carry random sof/pixel garbage to prove pix_valid qualifies them
    task automatic applyStimulus(input logic sof, input logic [PIX_W-1:0] p, input int idle_pct);
        while (int'($urandom_range(99)) < idle_pct) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.sof       = 1'($urandom_range(1));
            bus.pix_in    = PIX_W'($urandom);
        end
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.sof       = sof;
        bus.pix_in    = p;
        model_accept(sof, p, edge_no + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.sof       = 1'b0;
        end
    endtask

    task automatic send_frame(input pat_t pat, input int n_pix, input int idle_pct, input bit use_sof);
        for (int i = 0; i < n_pix; i++) begin
            applyStimulus(use_sof && (i == 0), pix_of(pat, i / IMG_W, i % IMG_W), idle_pct);
            if (i == 2 * IMG_W + 2) acc22_edge = edge_no + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        rst_n         = 1'b0;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        #1;
        checkOutput("r_valid_async_reset", int'(bus.r_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: every r_valid must match the next queued launch in value and timing
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            if (bus.r_valid === 1'b1) begin
                obs_q.push_back(int'(bus.r_out));
                obs_edge_q.push_back(edge_no);
                if (exp_q.size() == 0) begin
                    checkOutput("r_valid_without_launch", int'(bus.r_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("r_out_vs_model", int'(bus.r_out), e.value);
                    checkOutput("r_valid_edge", edge_no, e.edge_no);
                end
            end
        end
    end

    initial begin
        vec_t vecs [6];
        int   cc;
        int   n;
        int   idle_pct;

        vecs[0] = '{"const100",   PAT_CONST,   0,  84, 0,     0};
        vecs[1] = '{"hramp",      PAT_HRAMP,   0,  84, 256,   256};
        vecs[2] = '{"diag",       PAT_DIAG,    0,  84, 128,   128};
        vecs[3] = '{"vstep10",    PAT_STEP10,  0,  84, 1600,  0};
        vecs[4] = '{"vstep255",   PAT_STEP255, 0,  84, 65535, 0};
        vecs[5] = '{"hramp_gaps", PAT_HRAMP,   40, 84, 256,   256};

        bus.sof       = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_r_valid", int'(bus.r_valid), 0);
        checkOutput("reset_r_out", int'(bus.r_out), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            obs_q.delete();
            obs_edge_q.delete();
            send_frame(vecs[v].pat, FRAME, vecs[v].idle_pct, 1'b1);
            idle(6);
            checkOutput({vecs[v].name, "_count"}, obs_q.size(), vecs[v].exp_count);
            if (obs_edge_q.size() > 0)
                checkOutput({vecs[v].name, "_first_latency"}, obs_edge_q[0] - acc22_edge, 3);
            for (int k = 0; k < obs_q.size(); k++) begin
                cc = k % (IMG_W - 2) + 1;
                checkOutput({vecs[v].name, "_value"}, obs_q[k],
                            (cc == 7 || cc == 8) ? vecs[v].exp_step : vecs[v].exp_flat);
            end
            if (vecs[v].pat == PAT_STEP255 && obs_q.size() > 6)
                checkOutput("sqrt_of_saturated", isqrt(obs_q[6]), 255);
        end

        // sof arriving as pixel (4,5): 31 launches before it, then a clean frame
        obs_q.delete();
        send_frame(PAT_DIAG, 4 * IMG_W + 5, 0, 1'b1);
        send_frame(PAT_HRAMP, FRAME, 0, 1'b1);
        idle(6);
        checkOutput("sof_restart_count", obs_q.size(), 31 + 84);

        // Reset right after pixel (4,4): three in-flight results must vanish
        obs_q.delete();
        send_frame(PAT_DIAG, 4 * IMG_W + 5, 0, 1'b1);
        do_reset();
        idle(4);
        checkOutput("reset_pre_count", obs_q.size(), 28);
        obs_q.delete();
        send_frame(PAT_HRAMP, FRAME, 0, 1'b0);
        idle(6);
        checkOutput("reset_post_count", obs_q.size(), 84);
        for (int k = 0; k < obs_q.size(); k++)
            checkOutput("reset_post_value", obs_q[k], 256);

        // Random pixels, random gaps, occasional mid-frame sof
        for (int f = 0; f < 5; f++) begin
            n        = int'($urandom_range(3 * IMG_W, 9 * IMG_W));
            idle_pct = int'($urandom_range(50));
            for (int i = 0; i < n; i++)
                applyStimulus((i == 0) || ($urandom_range(199) == 0), PIX_W'($urandom), idle_pct);
        end
        idle(6);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
